nn_neuron_mac: RTL and testbench

- Downstream consumer of the feed-forward controller's 256-bit RAM read word.
- Treats the word as one weight row of 16 signed 16-bit weights and gates each weight by the binary input feature vector (x0..x3, zero-padded to 16 lanes).
- Accumulates one lane per cycle and emits the signed neuron sum plus a thresholded output bit through a valid/ready handshake.
- Sits between the weight RAM/controller and the output register that drives y0/y1.

---
 rtl/nn_pkg.sv | 23 ++
 rtl/nn_lane_mux.sv | 30 +++
 rtl/nn_neuron_mac.sv | 141 ++++++++++++++
 tb/tb_nn_neuron_mac.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neuron MAC slice: FSM state encoding, default
// geometry constants and a lane-extract helper for a packed weight row.
package nn_pkg;

    localparam int unsigned NN_LANES     = 16;
    localparam int unsigned NN_W_WIDTH   = 16;
    localparam int unsigned NN_ROW_WIDTH = NN_LANES * NN_W_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Returns weight lane 'lane' from a default-geometry row.
    function automatic logic [NN_W_WIDTH-1:0] lane_extract(
        input logic [NN_ROW_WIDTH-1:0] row,
        input logic [3:0]              lane
    );
        return row[int'(lane) * int'(NN_W_WIDTH) +: NN_W_WIDTH];
    endfunction

endpackage

// File: rtl/nn_lane_mux.sv
// Combinational lane selector: picks one weight out of a captured row,
// sign-extends it to the accumulator width, and returns its gate bit.
// Ports:
//   row      captured weight row, lane i at [i*W_WIDTH +: W_WIDTH]
//   x        captured feature vector, bit i gates lane i
//   lane     lane index to select
//   weight_c sign-extended weight of the selected lane
//   gate_c   feature bit of the selected lane
module nn_lane_mux #(
    parameter int unsigned LANES     = 16,
    parameter int unsigned W_WIDTH   = 16,
    parameter int unsigned ACC_WIDTH = 24,
    parameter int unsigned LANE_W    = 4
) (
    input  logic [LANES*W_WIDTH-1:0] row,
    input  logic [LANES-1:0]         x,
    input  logic [LANE_W-1:0]        lane,
    output logic [ACC_WIDTH-1:0]     weight_c,
    output logic                     gate_c
);

    logic [W_WIDTH-1:0] raw;

    always_comb begin
        raw      = row[int'(lane) * int'(W_WIDTH) +: W_WIDTH];
        weight_c = {{(ACC_WIDTH - W_WIDTH){raw[W_WIDTH-1]}}, raw};
        gate_c   = x[lane];
    end

endmodule

// File: rtl/nn_neuron_mac.sv
// Single-neuron multiply-accumulate: captures one weight row and a binary
// feature vector, accumulates the gated weights one lane per cycle, then
// presents the signed sum and a thresholded bit until the consumer accepts.
// Ports:
//   CLK, RST             clock, asynchronous active-low reset
//   row_valid/row_ready  row input handshake (ready only in IDLE)
//   row_data, x_bits     weight row and feature gate vector
//   sum_valid/sum_ready  result handshake
//   sum_data, y_bit      signed neuron sum, 1 iff sum > 0
//   rows_done            count of results handed off (wrapping)
module nn_neuron_mac
    import nn_pkg::*;
#(
    parameter int unsigned LANES     = NN_LANES,
    parameter int unsigned W_WIDTH   = NN_W_WIDTH,
    parameter int unsigned ACC_WIDTH = 24,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     row_valid,
    output logic                     row_ready,
    input  logic [LANES*W_WIDTH-1:0] row_data,
    input  logic [LANES-1:0]         x_bits,
    output logic                     sum_valid,
    input  logic                     sum_ready,
    output logic [ACC_WIDTH-1:0]     sum_data,
    output logic                     y_bit,
    output logic [CNT_WIDTH-1:0]     rows_done
);

    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    // The accumulator must hold LANES worst-case weights without overflow.
    if (ACC_WIDTH < W_WIDTH + $clog2(LANES)) begin : g_bad_acc_width
        $error("nn_neuron_mac: ACC_WIDTH too narrow for LANES*W_WIDTH sum");
    end

    state_t                   state;
    state_t                   state_nxt;
    logic [LANES*W_WIDTH-1:0] row_q;
    logic [LANES-1:0]         x_q;
    logic [LANE_W-1:0]        lane;
    logic [ACC_WIDTH-1:0]     acc;
    logic [ACC_WIDTH-1:0]     acc_nxt;
    logic [ACC_WIDTH-1:0]     weight;
    logic                     gate;
    logic                     accept;
    logic                     last;
    logic                     handoff;

    nn_lane_mux #(
        .LANES    (LANES),
        .W_WIDTH  (W_WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .LANE_W   (LANE_W)
    ) u_lane_mux (
        .row     (row_q),
        .x       (x_q),
        .lane    (lane),
        .weight_c(weight),
        .gate_c  (gate)
    );

    // Next-state and strobe decode.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        handoff   = 1'b0;
        acc_nxt   = gate ? (acc + weight) : acc;
        case (state)
            ST_IDLE: begin
                if (row_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                if (lane == LAST_LANE) begin
                    last      = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (sum_ready) begin
                    handoff   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; row_ready is a registered decode of the next state,
    // so it never depends combinationally on row_valid.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            row_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            row_ready <= (state_nxt == ST_IDLE);
        end
    end

    // Capture, accumulate, result and hand-off counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            row_q     <= '0;
            x_q       <= '0;
            lane      <= '0;
            acc       <= '0;
            sum_data  <= '0;
            y_bit     <= 1'b0;
            sum_valid <= 1'b0;
            rows_done <= '0;
        end else begin
            if (accept) begin
                row_q <= row_data;
                x_q   <= x_bits;
                acc   <= '0;
                lane  <= '0;
            end else if (state == ST_ACC) begin
                acc  <= acc_nxt;
                lane <= lane + LANE_W'(1);
            end
            if (last) begin
                sum_data  <= acc_nxt;
                y_bit     <= !acc_nxt[ACC_WIDTH-1] && (acc_nxt != '0);
                sum_valid <= 1'b1;
            end
            if (handoff) begin
                sum_valid <= 1'b0;
                rows_done <= rows_done + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_nn_neuron_mac.sv
// Directed bench for nn_neuron_mac: reset, arithmetic corner cases,
// latency, backpressure, mid-operation reset and back-to-back throughput.
module tb_nn_neuron_mac;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         row_valid = 1'b0;
    logic         row_ready;
    logic [255:0] row_data = '0;
    logic [15:0]  x_bits = '0;
    logic         sum_valid;
    logic         sum_ready = 1'b0;
    logic [23:0]  sum_data;
    logic         y_bit;
    logic [7:0]   rows_done;

    int checks   = 0;
    int failures = 0;
    int exp_rd   = 0;

    nn_neuron_mac dut (
        .CLK      (CLK),
        .RST      (RST),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .row_data (row_data),
        .x_bits   (x_bits),
        .sum_valid(sum_valid),
        .sum_ready(sum_ready),
        .sum_data (sum_data),
        .y_bit    (y_bit),
        .rows_done(rows_done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, $signed(got), got,
                     $signed(exp), exp);
        end
    endtask

    function automatic logic [255:0] fill_row(input logic [15:0] w);
        logic [255:0] r;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = w;
        return r;
    endfunction

    function automatic logic [31:0] sx(input logic [23:0] v);
        return {{8{v[23]}}, v};
    endfunction

    // Send one row, check latency and result, optionally stall, then hand off.
    task automatic run_row(input string tag, input logic [255:0] row, input logic [15:0] x,
                           input int exp_sum, input logic exp_y, input int stall);
        int cnt;
        @(negedge CLK);
        check({tag, "_row_ready"}, 32'(row_ready), 32'd1);
        row_valid = 1'b1;
        row_data  = row;
        x_bits    = x;
        @(posedge CLK);
        #1;
        row_valid = 1'b0;
        row_data  = ~row;
        x_bits    = ~x;
        cnt = 0;
        while (cnt < 40) begin
            @(negedge CLK);
            if (sum_valid) break;
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'd16);
        check({tag, "_sum"}, sx(sum_data), 32'(exp_sum));
        check({tag, "_y"}, 32'(y_bit), 32'(exp_y));
        for (int i = 0; i < stall; i++) begin
            if (i == 3) begin
                row_valid = 1'b1;
                row_data  = fill_row(16'h0100);
                x_bits    = 16'hFFFF;
            end
            if (i == 4) row_valid = 1'b0;
            @(negedge CLK);
            check({tag, "_hold_sum"}, sx(sum_data), 32'(exp_sum));
            check({tag, "_hold_valid"}, 32'(sum_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(row_ready), 32'd0);
        end
        sum_ready = 1'b1;
        @(posedge CLK);
        #1;
        sum_ready = 1'b0;
        exp_rd = (exp_rd + 1) % 256;
        @(negedge CLK);
        check({tag, "_post_valid"}, 32'(sum_valid), 32'd0);
        check({tag, "_rows_done"}, 32'(rows_done), 32'(exp_rd));
        check({tag, "_post_ready"}, 32'(row_ready), 32'd1);
    endtask

    initial begin
        logic [255:0] r;
        int n;
        int cyc;
        int last_cyc;

        // Reset held for 3 cycles.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_row_ready", 32'(row_ready), 32'd1);
        check("rst_sum_valid", 32'(sum_valid), 32'd0);
        check("rst_sum_data", sx(sum_data), 32'd0);
        check("rst_y_bit", 32'(y_bit), 32'd0);
        check("rst_rows_done", 32'(rows_done), 32'd0);

        // Reset asserted while lane 7 is being accumulated.
        row_valid = 1'b1;
        row_data  = fill_row(16'd1);
        x_bits    = 16'h000F;
        @(posedge CLK);
        #1;
        row_valid = 1'b0;
        repeat (7) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("midrst_row_ready", 32'(row_ready), 32'd1);
        check("midrst_sum_valid", 32'(sum_valid), 32'd0);
        check("midrst_sum_data", sx(sum_data), 32'd0);
        check("midrst_y_bit", 32'(y_bit), 32'd0);
        check("midrst_rows_done", 32'(rows_done), 32'(exp_rd));
        repeat (2) @(negedge CLK);
        RST = 1'b1;

        // All weights +1, four lanes enabled.
        run_row("ones4", fill_row(16'd1), 16'h000F, 4, 1'b1, 0);

        // Ramp weights i-8, all lanes, with 10 cycles of backpressure.
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = 16'(i - 8);
        run_row("ramp", r, 16'hFFFF, -8, 1'b0, 10);

        // Most negative sum.
        run_row("min", fill_row(16'h8000), 16'hFFFF, -524288, 1'b0, 0);

        // Most positive sum.
        run_row("max", fill_row(16'h7FFF), 16'hFFFF, 524272, 1'b1, 0);

        // Exact zero sum gives y_bit=0.
        r = fill_row(16'h7FFF);
        r[15:0]  = 16'd5;
        r[31:16] = 16'hFFFB;
        run_row("zero_sum", r, 16'h0003, 0, 1'b0, 0);

        // No features enabled.
        run_row("x_zero", fill_row(16'h1234), 16'h0000, 0, 1'b0, 0);

        // Single high lane only.
        r = fill_row(16'hFFFF);
        r[255:240] = 16'd300;
        run_row("lane15", r, 16'h8000, 300, 1'b1, 0);

        // 257 back-to-back rows with sum_ready held high.
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        exp_rd = 0;
        @(negedge CLK);
        row_valid = 1'b1;
        row_data  = fill_row(16'd1);
        x_bits    = 16'h0001;
        sum_ready = 1'b1;
        n = 0;
        cyc = 0;
        last_cyc = 0;
        while (n < 257 && cyc < 257 * 18 + 100) begin
            @(negedge CLK);
            cyc++;
            if (sum_valid) begin
                n++;
                check("b2b_sum", sx(sum_data), 32'd1);
                if (n > 1) check("b2b_period", 32'(cyc - last_cyc), 32'd18);
                last_cyc = cyc;
                if (n == 257) row_valid = 1'b0;
            end
        end
        check("b2b_count", 32'(n), 32'd257);
        @(negedge CLK);
        sum_ready = 1'b0;
        check("b2b_rows_done_wrap", 32'(rows_done), 32'd1);
        check("b2b_row_ready", 32'(row_ready), 32'd1);
        check("b2b_sum_valid", 32'(sum_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
